// File: rtl/tx_write_sched_pkg.sv
// Shared types for the transmit-FIFO write scheduler: channel tags, FSM states
// and the existing operating-configuration word.
package tx_write_sched_pkg;

  typedef enum logic {
    CH_L = 1'b0,
    CH_R = 1'b1
  } ch_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXP_L = 2'd1,
    S_EXP_R = 2'd2
  } sched_state_t;

  typedef enum logic [1:0] {
    f16bits = 2'd0,
    f24bits = 2'd1,
    f32bits = 2'd2
  } frame_size_t;

  typedef struct packed {
    logic        stereo;
    logic        stop;
    frame_size_t frame_size;
  } OP_t;

  // Channel the FSM is waiting for; S_IDLE never grants, so its value is moot.
  function automatic ch_t expected_ch(input sched_state_t s);
    return (s == S_EXP_R) ? CH_R : CH_L;
  endfunction

endpackage

// File: rtl/tx_write_sched_rr_arb2.sv
// Two-way round-robin arbiter; rr_last remembers the most recent winner so that
// under contention the other source is granted next.
module tx_write_sched_rr_arb2 (
  input  logic       wclk,
  input  logic       rst_,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic rr_last_q;
  logic rr_last_d;

  // grant decode
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = rr_last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end else begin
      gnt_o = 2'b00;
    end
  end

  // last-winner next state
  always_comb begin
    if (gnt_o[1]) begin
      rr_last_d = 1'b1;
    end else if (gnt_o[0]) begin
      rr_last_d = 1'b0;
    end else begin
      rr_last_d = rr_last_q;
    end
  end

  // last-winner register; resets to 1 so src0 wins the first contention
  always_ff @(posedge wclk or negedge rst_) begin
    if (!rst_) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/tx_write_sched.sv
// Transmit-FIFO write scheduler: arbitrates CPU/DMA samples onto the FIFO write
// port, enforces L/R order in stereo and throttles against full/almost-full.
module tx_write_sched
  import tx_write_sched_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             wclk,
  input  logic             rst_,
  input  OP_t              op_i,
  input  logic             src0_valid_i,
  input  logic [WIDTH-1:0] src0_data_i,
  input  ch_t              src0_ch_i,
  output logic             src0_ready_o,
  input  logic             src1_valid_i,
  input  logic [WIDTH-1:0] src1_data_i,
  input  ch_t              src1_ch_i,
  output logic             src1_ready_o,
  output logic [WIDTH-1:0] fifo_din_o,
  output logic             fifo_wr_en_o,
  input  logic             fifo_full_i,
  input  logic             fifo_al_full_i,
  output logic             dreq_o,
  output logic             ch_err_o,
  output logic [CNTW-1:0]  wr_count_o
);

  sched_state_t     state_q, state_d;
  logic             wr_en_q, wr_en_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             ch_err_q, ch_err_d;
  logic             dreq_q, dreq_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic             can_wr_s;
  logic [1:0]       gnt_s;
  logic             acc_s;
  logic             wr_ok_s;
  ch_t              sel_ch_s;
  logic [WIDTH-1:0] sel_data_s;

  function automatic logic [WIDTH-1:0] pack_sample(input logic [WIDTH-1:0] d,
                                                   input frame_size_t     fs);
    if (fs == f16bits) begin
      return {{(WIDTH-16){1'b0}}, d[WIDTH-1 -: 16]};
    end else begin
      return d;
    end
  endfunction

  tx_write_sched_rr_arb2 u_arb (
    .wclk  (wclk),
    .rst_  (rst_),
    .req_i ({src1_valid_i, src0_valid_i}),
    .en_i  (can_wr_s),
    .gnt_o (gnt_s)
  );

  // state register
  always_ff @(posedge wclk or negedge rst_) begin
    if (!rst_) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    if (op_i.stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_EXP_L;
        S_EXP_L: state_d = (wr_ok_s && op_i.stereo) ? S_EXP_R : S_EXP_L;
        S_EXP_R: state_d = wr_ok_s ? S_EXP_L : S_EXP_R;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs: the al_full term blocks back-to-back writes so full is seen first.
  always_comb begin
    can_wr_s   = (state_q != S_IDLE) && !op_i.stop && !fifo_full_i &&
                 !(wr_en_q && fifo_al_full_i);
    acc_s      = |gnt_s;
    sel_ch_s   = gnt_s[1] ? src1_ch_i : src0_ch_i;
    sel_data_s = gnt_s[1] ? src1_data_i : src0_data_i;
    wr_ok_s    = acc_s && (!op_i.stereo || (sel_ch_s == expected_ch(state_q)));
    wr_en_d    = wr_ok_s;
    ch_err_d   = acc_s && !wr_ok_s;
    din_d      = wr_ok_s ? pack_sample(sel_data_s, op_i.frame_size) : din_q;
    cnt_d      = cnt_q + {{(CNTW-1){1'b0}}, wr_ok_s};
    dreq_d     = (state_q != S_IDLE) && !op_i.stop && !fifo_al_full_i;
  end

  // output register stage
  always_ff @(posedge wclk or negedge rst_) begin
    if (!rst_) begin
      wr_en_q  <= 1'b0;
      din_q    <= {WIDTH{1'b0}};
      ch_err_q <= 1'b0;
      dreq_q   <= 1'b0;
      cnt_q    <= {CNTW{1'b0}};
    end else begin
      wr_en_q  <= wr_en_d;
      din_q    <= din_d;
      ch_err_q <= ch_err_d;
      dreq_q   <= dreq_d;
      cnt_q    <= cnt_d;
    end
  end

  assign src0_ready_o = gnt_s[0];
  assign src1_ready_o = gnt_s[1];
  assign fifo_wr_en_o = wr_en_q;
  assign fifo_din_o   = din_q;
  assign ch_err_o     = ch_err_q;
  assign dreq_o       = dreq_q;
  assign wr_count_o   = cnt_q;

endmodule
